// File: rtl/siso_using_jk_pkg.sv
// Shared definitions for the JK-based serial delay line: default depth and
// the JK next-state function used by every stage.
package siso_using_jk_pkg;

    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    // Full JK truth table; {J,K} selects the operation applied to the current Q.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        jk_op_e op;
        op = jk_op_e'({j, k});
        case (op)
            JK_HOLD:   jk_next = q;
            JK_RESET:  jk_next = 1'b0;
            JK_SET:    jk_next = 1'b1;
            JK_TOGGLE: jk_next = ~q;
            default:   jk_next = q;
        endcase
    endfunction

endpackage

// File: rtl/siso_using_jk_jk_ff.sv
// Single JK flip-flop with asynchronous active-high clear; building block of
// the serial delay chain.
module jk_ff
    import siso_using_jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next-state selection from the JK inputs.
    always_comb begin
        q_d = jk_next(j, k, q_q);
    end

    // State register; reset wins over the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/siso_using_jk.sv
// Serial-in serial-out delay line of DEPTH JK stages, each wired as a D element
// (J = stage input, K = its complement); sout lags sin by DEPTH clock edges.
module siso_using_jk
    import siso_using_jk_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic sout
);

    logic [DEPTH-1:0] q_s;
    logic [DEPTH-1:0] d_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign d_s[i] = sin;
        end else begin : g_link
            assign d_s[i] = q_s[i-1];
        end

        jk_ff u_jk (
            .clk (clk),
            .rst (rst),
            .j   (d_s[i]),
            .k   (~d_s[i]),
            .q   (q_s[i])
        );
    end

    assign sout = q_s[DEPTH-1];

endmodule

// File: tb/tb_siso_using_jk.sv
// Scoreboard bench for siso_using_jk (DEPTH=4) plus a direct unit check of jk_ff.
module tb_siso_using_jk;

    localparam int DEPTH = 4;

    typedef struct {
        string name;
        logic  val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin = 1'bx;
    logic sout;

    logic jk_rst = 1'b1;
    logic j = 1'b0;
    logic k = 1'b0;
    logic jq;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    siso_using_jk #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .sin  (sin),
        .sout (sout)
    );

    jk_ff u_jk (
        .clk (clk),
        .rst (jk_rst),
        .j   (j),
        .k   (k),
        .q   (jq)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Monitor: one expected sout value is consumed after every active edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check1(e.name, sout, e.val);
        end
    end

    task automatic run_vec(input string name, input logic [31:0] sin_v,
                           input logic [31:0] exp_v, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            @(negedge clk);
            sin = sin_v[i];
            e.name = $sformatf("%s[%0d]", name, i);
            e.val  = exp_v[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic jk_step(input string name, input logic jv, input logic kv, input logic req);
        @(negedge clk);
        j = jv;
        k = kv;
        @(posedge clk);
        #1;
        check1(name, jq, req);
    endtask

    initial begin
        // Reset held with X on sin: no X may reach the stages.
        repeat (2) begin
            @(posedge clk);
            #1;
            check1("reset_sout", sout, 1'b0);
            check4("reset_stages", dut.q_s, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        sin = 1'b0;

        // 1,0,1,0 then zeros: 1 after edge 4, 1 after edge 6.
        run_vec("pattern", 32'b0000000101, 32'b0000101000, 10);
        drain();
        // Single pulse sampled at edge 2 shows up after edge 5 only.
        run_vec("pulse", 32'b00000010, 32'b00010000, 8);
        drain();
        // Eight ones then zeros: sout high after edges 4..11.
        run_vec("ones", 32'b000011111111, 32'b011111111000, 12);
        drain();
        run_vec("mixed", 32'b000010011011, 32'b010011011000, 12);
        drain();

        // Fill with ones, then reset between clock edges.
        run_vec("fill", 32'b1111, 32'b1000, 4);
        drain();
        check4("fill_stages", dut.q_s, 4'b1111);
        check1("fill_sout", sout, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("async_rst_sout", sout, 1'b0);
        check4("async_rst_stages", dut.q_s, 4'b0000);
        sin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_vec("post_rst", 32'b000000, 32'b000000, 6);
        drain();

        // jk_ff unit: every J/K combination from Q=0 and from Q=1.
        @(negedge clk);
        check1("jk_reset", jq, 1'b0);
        jk_rst = 1'b0;
        jk_step("jk_00_from0", 1'b0, 1'b0, 1'b0);
        jk_step("jk_01_from0", 1'b0, 1'b1, 1'b0);
        jk_step("jk_10_from0", 1'b1, 1'b0, 1'b1);
        jk_step("jk_00_from1", 1'b0, 1'b0, 1'b1);
        jk_step("jk_10_from1", 1'b1, 1'b0, 1'b1);
        jk_step("jk_01_from1", 1'b0, 1'b1, 1'b0);
        jk_step("jk_11_from0", 1'b1, 1'b1, 1'b1);
        jk_step("jk_11_from1", 1'b1, 1'b1, 1'b0);
        jk_step("jk_11_again", 1'b1, 1'b1, 1'b1);
        #2;
        jk_rst = 1'b1;
        #1;
        check1("jk_async_rst", jq, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
